// File: rtl/mem_pkg.sv
// Shared memory-access definitions: funct3 encodings, controller states and
// the alignment check shared by the data-memory controller and the fetch unit.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_DATA,
        ST_W,
        RMW_RD,
        RMW_MRG,
        RMW_WR,
        RESP
    } mem_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and the
// byte/half merge used for read-modify-write stores.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lane)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase

        merge_data = rdata;
        if (funct3 == F3_B) begin
            case (lane)
                2'd0: merge_data[7:0]   = wdata[7:0];
                2'd1: merge_data[15:8]  = wdata[7:0];
                2'd2: merge_data[23:16] = wdata[7:0];
                2'd3: merge_data[31:24] = wdata[7:0];
                default: merge_data = rdata;
            endcase
        end else if (funct3 == F3_H) begin
            if (lane[1]) merge_data[31:16] = wdata;
            else         merge_data[15:0]  = wdata;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I load/store sequencer for a single-port, word-wide data memory with
// registered read data; sub-word stores use read-modify-write.
//
// state   | meaning
// IDLE    | ready for a request
// LD_REQ  | read strobe for a load
// LD_DATA | read data valid, extract and register result
// ST_W    | full-word write strobe
// RMW_RD  | read strobe for a sub-word store
// RMW_MRG | merge store lane into the old word
// RMW_WR  | write back the merged word
// RESP    | one-cycle completion pulse
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic        mem_r_enable,
    output logic        mem_w_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    mem_state_t  state, state_nxt;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        fault_q;

    logic        accept;
    logic        illegal_f3;
    logic        out_of_range;
    logic        req_fault;
    logic [31:0] offset;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign req_ready    = (state == IDLE);
    assign accept       = req_valid & req_ready;
    assign offset       = req_addr - BASE_ADDR;
    assign out_of_range = (req_addr < BASE_ADDR) || ((offset >> 2) >= MEM_WORDS_W);
    assign illegal_f3   = req_we ? (req_funct3 > F3_W)
                                 : ((req_funct3 == 3'd3) || (req_funct3 > F3_HU));
    assign req_fault    = illegal_f3 | out_of_range | is_misaligned(req_funct3, req_addr[1:0]);

    // Strobes come straight from state so an async reset removes them at once.
    assign mem_r_enable = (state == LD_REQ) || (state == RMW_RD);
    assign mem_w_enable = (state == ST_W)   || (state == RMW_WR);
    assign resp_valid   = (state == RESP);
    assign resp_fault   = resp_valid & fault_q;

    lsu_align u_lsu_align (
        .funct3     (funct3_q),
        .lane       (lane_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault)                state_nxt = RESP;
                    else if (!req_we)             state_nxt = LD_REQ;
                    else if (req_funct3 == F3_W)  state_nxt = ST_W;
                    else                          state_nxt = RMW_RD;
                end
            end
            LD_REQ:  state_nxt = LD_DATA;
            LD_DATA: state_nxt = RESP;
            ST_W:    state_nxt = RESP;
            RMW_RD:  state_nxt = RMW_MRG;
            RMW_MRG: state_nxt = RMW_WR;
            RMW_WR:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q   <= 3'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 16'd0;
            fault_q    <= 1'b0;
            resp_rdata <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            if (accept) begin
                funct3_q   <= req_funct3;
                lane_q     <= req_addr[1:0];
                wdata_q    <= req_wdata[15:0];
                fault_q    <= req_fault;
                resp_rdata <= 32'd0;
                // A rejected request leaves the memory-side registers alone.
                if (!req_fault) begin
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_wdata <= req_wdata;
                end
            end
            if (state == LD_DATA) resp_rdata <= load_data;
            if (state == RMW_MRG) mem_wdata  <= merge_data;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a bench-side memory plus a shadow copy
// supply expected load/store results, latencies and strobe counts.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.MEM_WORDS(256), .BASE_ADDR(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_addr     (mem_addr),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];

    always @(posedge clk) begin
        if (mem_w_enable) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_r_enable) mem_rdata <= mem[mem_addr[9:2]];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] waddr;
        logic [31:0] wword;
        int          n_rd;
        int          n_wr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    bit   busy = 0;
    logic prev_resp = 1'b0;

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) begin
            busy = 1;
            cyc  = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) cyc++;
            if (mem_r_enable || mem_w_enable) begin
                check_val("strobe_excl", {31'd0, mem_r_enable & mem_w_enable}, 32'd0);
                check_val("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
                if (sb_q.size() == 0) begin
                    check_val("stray_strobe", {31'd0, mem_r_enable | mem_w_enable}, 32'd0);
                end else begin
                    check_val("mem_addr", mem_addr, sb_q[0].waddr);
                    if (mem_w_enable) begin
                        wr_cnt++;
                        check_val("w_data", mem_wdata, sb_q[0].wword);
                        check_val("w_cycle", cyc, sb_q[0].lat - 1);
                    end else begin
                        rd_cnt++;
                    end
                end
            end
            if (resp_valid) begin
                check_val("resp_pulse", {31'd0, prev_resp}, 32'd0);
                if (sb_q.size() == 0) begin
                    check_val("stray_resp", {31'd0, resp_valid}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("resp_fault", {31'd0, resp_fault}, {31'd0, mon_e.fault});
                    check_val("resp_rdata", resp_rdata, mon_e.rdata);
                    check_val("latency", cyc, mon_e.lat);
                    check_val("n_reads", rd_cnt, mon_e.n_rd);
                    check_val("n_writes", wr_cnt, mon_e.n_wr);
                    rd_cnt = 0;
                    wr_cnt = 0;
                    busy   = 0;
                end
            end
            prev_resp = resp_valid;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        logic        illegal, mis, oor;
        int          idx, sh, hsh, n;
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis     = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
        oor     = (addr >> 2) >= 32'd256;
        e.fault = illegal | mis | oor;
        e.rdata = 32'd0;
        e.waddr = {addr[31:2], 2'b00};
        e.wword = 32'd0;
        e.n_rd  = 0;
        e.n_wr  = 0;
        e.lat   = 1;
        if (!e.fault) begin
            idx = int'(addr[9:2]);
            w   = shadow[idx];
            sh  = 8 * int'(addr[1:0]);
            hsh = 16 * int'(addr[1]);
            b   = 8'(w >> sh);
            h   = 16'(w >> hsh);
            if (!we) begin
                e.lat  = 3;
                e.n_rd = 1;
                case (f3)
                    3'd0:    e.rdata = {{24{b[7]}}, b};
                    3'd1:    e.rdata = {{16{h[15]}}, h};
                    3'd2:    e.rdata = w;
                    3'd4:    e.rdata = {24'd0, b};
                    default: e.rdata = {16'd0, h};
                endcase
            end else if (f3 == 3'd2) begin
                e.lat   = 2;
                e.n_wr  = 1;
                e.wword = wd;
                shadow[idx] = wd;
            end else begin
                e.lat  = 4;
                e.n_rd = 1;
                e.n_wr = 1;
                if (f3 == 3'd0) e.wword = (w & ~(32'hFF << sh)) | ({24'd0, wd[7:0]} << sh);
                else            e.wword = (w & ~(32'hFFFF << hsh)) | ({16'd0, wd[15:0]} << hsh);
                shadow[idx] = e.wword;
            end
        end
        sb_q.push_back(e);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs after the accept edge; the request must already be latched.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("resp_timeout", sb_q.size(), 32'd0);
        if (sb_q.size() != 0) begin
            sb_q.delete();
            busy   = 0;
            rd_cnt = 0;
            wr_cnt = 0;
        end
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        issue(we, f3, addr, wd);
        wait_done();
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] saved;
        logic [31:0] ra;
        int          n;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            mem[i]    = v;
            shadow[i] = v;
        end

        // reset values
        repeat (2) @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        check_val("rst_strobes", {30'd0, mem_r_enable, mem_w_enable}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("idle_strobes", {30'd0, mem_r_enable, mem_w_enable}, 32'd0);
            check_val("idle_ready", {31'd0, req_ready}, 32'd1);
        end

        // word store / load
        op(1'b1, 3'd2, 32'h190, 32'h11223344);
        check_val("mem_sw", mem[100], 32'h11223344);
        op(1'b0, 3'd2, 32'h190, 32'h0);

        // byte RMW and byte loads
        op(1'b1, 3'd0, 32'h191, 32'h5A5A5AAB);
        check_val("mem_sb", mem[100], 32'h1122AB44);
        op(1'b0, 3'd0, 32'h191, 32'h0);
        op(1'b0, 3'd4, 32'h191, 32'h0);

        // half RMW and half loads
        op(1'b1, 3'd1, 32'h192, 32'hCDEF8001);
        check_val("mem_sh", mem[100], 32'h8001AB44);
        op(1'b0, 3'd1, 32'h192, 32'h0);
        op(1'b0, 3'd5, 32'h192, 32'h0);
        op(1'b0, 3'd0, 32'h190, 32'h0);

        // faults
        op(1'b0, 3'd2, 32'h192, 32'h0);
        op(1'b1, 3'd1, 32'h193, 32'hFFFF);
        op(1'b0, 3'd2, 32'h400, 32'h0);
        op(1'b0, 3'd3, 32'h100, 32'h0);
        op(1'b1, 3'd5, 32'h100, 32'h12345678);
        op(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1);
        op(1'b0, 3'd6, 32'h104, 32'h0);
        check_val("mem_after_faults", mem[100], 32'h8001AB44);

        // random mix
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? $urandom : {22'd0, 10'($urandom_range(0, 1023))};
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
        end

        // reset while the merged word is being written
        saved = shadow[50];
        issue(1'b1, 3'd0, 32'h0C9, 32'h77);
        n = 0;
        while (!mem_w_enable && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("rmw_wr_reached", {31'd0, mem_w_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_drop_wen", {31'd0, mem_w_enable}, 32'd0);
        check_val("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
        sb_q.delete();
        busy      = 0;
        rd_cnt    = 0;
        wr_cnt    = 0;
        prev_resp = 1'b0;
        shadow[50] = saved;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_val("post_rst_resp", {31'd0, resp_valid}, 32'd0);
        end
        check_val("no_partial_write", mem[50], saved);
        op(1'b1, 3'd2, 32'h0C8, 32'hCAFEF00D);
        check_val("mem_post_rst_sw", mem[50], 32'hCAFEF00D);
        op(1'b0, 3'd2, 32'h0C8, 32'h0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL global_timeout: simulation did not complete by %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "global timeout");
    end

endmodule
